// File: rtl/neuron_axi_slave.sv
// AXI4-Lite slave holding four 32-bit neuron parameter registers.
// Registers are mirrored on REG0..REG3, and REG_WR flags each completed write.
module neuron_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3,
    output logic [3:0]                      REG_WR
);

    localparam int ADDR_LSB  = 2;
    localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
        input logic [NUM_BYTES-1:0]          strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < NUM_BYTES; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [3:0]                    r_reg_wr;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];

    logic                          w_wr_start;
    logic                          w_wr_fire;
    logic                          w_rd_start;
    logic                          w_rd_fire;
    logic [1:0]                    w_wr_idx;
    logic [1:0]                    w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_mux;
    logic                          w_unused_ok;

    // Address and data must both be present; readies stay low while a response is pending.
    assign w_wr_start = !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
    assign w_wr_fire  = r_awready && r_wready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_start = !r_arready && S_AXI_ARVALID && !r_rvalid;
    assign w_rd_fire  = r_arready && S_AXI_ARVALID;
    assign w_wr_idx   = S_AXI_AWADDR[ADDR_LSB +: 2];
    assign w_rd_idx   = S_AXI_ARADDR[ADDR_LSB +: 2];

    assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Read-data source selection by register index.
    always_comb begin
        w_rd_mux = {C_S_AXI_DATA_WIDTH{1'b0}};
        case (w_rd_idx)
            2'd0:    w_rd_mux = r_regs[0];
            2'd1:    w_rd_mux = r_regs[1];
            2'd2:    w_rd_mux = r_regs[2];
            2'd3:    w_rd_mux = r_regs[3];
            default: w_rd_mux = {C_S_AXI_DATA_WIDTH{1'b0}};
        endcase
    end

    // Write address/data handshake, write response and the write strobe pulse.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_reg_wr  <= 4'b0000;
        end else begin
            r_awready <= w_wr_start;
            r_wready  <= w_wr_start;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end else begin
                r_bvalid <= r_bvalid;
            end
            r_reg_wr  <= w_wr_fire ? sel_onehot(w_wr_idx) : 4'b0000;
        end
    end

    // Register file, byte-lane masked by WSTRB.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= {C_S_AXI_DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_fire && (w_wr_idx == 2'(i))) begin
                    r_regs[i] <= merge_bytes(r_regs[i], S_AXI_WDATA, S_AXI_WSTRB);
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Read handshake; RDATA samples the pre-write contents on a shared edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= {C_S_AXI_DATA_WIDTH{1'b0}};
        end else begin
            r_arready <= w_rd_start;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
                r_rdata  <= r_rdata;
            end else begin
                r_rvalid <= r_rvalid;
                r_rdata  <= r_rdata;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign REG0          = r_regs[0];
    assign REG1          = r_regs[1];
    assign REG2          = r_regs[2];
    assign REG3          = r_regs[3];
    assign REG_WR        = r_reg_wr;

endmodule

// File: tb/tb_neuron_axi_slave.sv
// Scoreboard bench for neuron_axi_slave: tasks drive AXI-Lite traffic and push
// expectations from a register-array model; a negedge monitor pops and compares.
module tb_neuron_axi_slave;

    logic        clk;
    logic        S_AXI_ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] REG0, REG1, REG2, REG3;
    logic [3:0]  REG_WR;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  m_regs [4];
    int           exp_b[$];
    logic [31:0]  exp_r[$];
    logic [3:0]   exp_wr[$];
    logic [127:0] exp_regs[$];

    bit   b_rand = 1'b0;
    bit   r_rand = 1'b0;
    logic b_force = 1'b1;
    logic r_force = 1'b1;

    neuron_axi_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3), .REG_WR(REG_WR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Response-ready drivers: random or forced level, updated just after each edge.
    initial begin
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            S_AXI_BREADY = b_rand ? 1'($urandom_range(0, 1)) : b_force;
            S_AXI_RREADY = r_rand ? 1'($urandom_range(0, 1)) : r_force;
        end
    end

    // Monitor: pops an expectation on every B/R handshake and REG_WR pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!S_AXI_ARESET) begin
                if (S_AXI_BVALID && S_AXI_BREADY) begin
                    if (exp_b.size() == 0) fail_now("b_spurious");
                    else begin
                        void'(exp_b.pop_front());
                        check("bresp", 128'(S_AXI_BRESP), 128'd0);
                    end
                end
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    if (exp_r.size() == 0) fail_now("r_spurious");
                    else begin
                        check("rdata", 128'(S_AXI_RDATA), 128'(exp_r.pop_front()));
                        check("rresp", 128'(S_AXI_RRESP), 128'd0);
                    end
                end
                if (REG_WR != 4'b0000) begin
                    if (exp_wr.size() == 0) fail_now("reg_wr_spurious");
                    else begin
                        check("reg_wr", 128'(REG_WR), 128'(exp_wr.pop_front()));
                        check("reg_file", {REG3, REG2, REG1, REG0}, exp_regs.pop_front());
                    end
                end
            end
        end
    end

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[3:2]);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
        end
        exp_b.push_back(1);
        exp_wr.push_back(4'b0001 << idx);
        exp_regs.push_back({m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    endtask

    task automatic model_read(input logic [3:0] addr);
        exp_r.push_back(m_regs[int'(addr[3:2])]);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        bit done;
        S_AXI_AWADDR  = addr;
        S_AXI_AWPROT  = 3'($urandom);
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (S_AXI_AWREADY && S_AXI_WREADY) done = 1'b1;
            n++;
        end
        if (!done) fail_now("aw_w_timeout");
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr);
        int n;
        bit done;
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (S_AXI_ARREADY) done = 1'b1;
            n++;
        end
        if (!done) fail_now("ar_timeout");
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        model_write(addr, data, strb);
        bus_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [3:0] addr);
        model_read(addr);
        bus_read(addr);
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        b_rand = 1'b0; r_rand = 1'b0; b_force = 1'b1; r_force = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (!S_AXI_BVALID && !S_AXI_RVALID && REG_WR == 4'b0000) done = 1'b1;
            n++;
        end
        if (!done) fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        S_AXI_ARESET = 1'b1;
        S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                             S_AXI_RVALID, REG_WR, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 128'd0);
        check("reset_regs", {REG3, REG2, REG1, REG0}, 128'd0);
        @(posedge clk);
        #1;
        S_AXI_ARESET = 1'b0;
        @(posedge clk);
        #1;

        // Basic write-then-read of every register.
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));

        // Byte-lane masking.
        do_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        do_write(4'h4, 32'h1234_5678, 4'b0101);
        wait_idle();
        check("strb_reg1", 128'(REG1), 128'(32'hFF34_FF78));

        // AW without W must not be accepted.
        S_AXI_AWADDR  = 4'hC;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_alone_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 128'd0);
            @(posedge clk);
            #1;
        end
        do_write(4'hC, 32'hCAFE_0001, 4'hF);

        // Stalled write response blocks a second write.
        wait_idle();
        b_force = 1'b0;
        do_write(4'h8, 32'h1111_2222, 4'hF);
        model_write(4'h0, 32'h3333_4444, 4'hF);
        fork
            bus_write(4'h0, 32'h3333_4444, 4'hF);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("b_hold", {S_AXI_BVALID, S_AXI_AWREADY}, 128'b10);
                end
                b_force = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Read and write of REG2 on the same edge returns the old value.
        wait_idle();
        do_write(4'h8, 32'hA, 4'hF);
        wait_idle();
        model_read(4'h8);
        model_write(4'h8, 32'hB, 4'hF);
        fork
            bus_write(4'h8, 32'hB, 4'hF);
            bus_read(4'h8);
        join
        do_read(4'h8);

        // Reset while a read response is stalled abandons it.
        wait_idle();
        r_force = 1'b0;
        do_read(4'h0);
        for (int i = 0; i < 20 && !S_AXI_RVALID; i++) @(negedge clk);
        check("rvalid_before_reset", 128'(S_AXI_RVALID), 128'd1);
        @(posedge clk);
        #1;
        S_AXI_ARESET = 1'b1;
        @(posedge clk);
        #1;
        S_AXI_ARESET = 1'b0;
        @(negedge clk);
        check("rst_rvalid", {S_AXI_RVALID, S_AXI_BVALID}, 128'd0);
        check("rst_regs", {REG3, REG2, REG1, REG0}, 128'd0);
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        exp_r.delete();
        r_force = 1'b1;
        repeat (10) @(negedge clk);
        check("no_resp_after_reset", {S_AXI_RVALID, S_AXI_BVALID}, 128'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random response back-pressure.
        b_rand = 1'b1;
        r_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(4'($urandom), $urandom, 4'($urandom));
            else do_read(4'($urandom));
        end

        wait_idle();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_b", 128'(exp_b.size()), 128'd0);
        check("drain_r", 128'(exp_r.size()), 128'd0);
        check("drain_wr", 128'(exp_wr.size()), 128'd0);
        check("final_regs", {REG3, REG2, REG1, REG0}, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_axi_slave.md
NEURON_AXI_SLAVE -- requirements
Module: neuron_axi_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, SHALL set the byte address width, giving 4 word registers.
REQ-003 S_AXI_ACLK  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 S_AXI_ARESET  in  1  SHALL be the synchronous, active-high reset.
REQ-005 S_AXI_AWADDR  in  4 and S_AXI_AWPROT  in  3 SHALL carry the write address and protection; AWPROT is ignored.
REQ-006 S_AXI_AWVALID  in  1 and S_AXI_AWREADY  out  1 SHALL form the write-address handshake.
REQ-007 S_AXI_WDATA  in  32 and S_AXI_WSTRB  in  4 SHALL carry the write data and byte enables.
REQ-008 S_AXI_WVALID  in  1 and S_AXI_WREADY  out  1 SHALL form the write-data handshake.
REQ-009 S_AXI_BRESP  out  2, S_AXI_BVALID  out  1 and S_AXI_BREADY  in  1 SHALL form the write-response channel.
REQ-010 S_AXI_ARADDR  in  4 and S_AXI_ARPROT  in  3 SHALL carry the read address and protection; ARPROT is ignored.
REQ-011 S_AXI_ARVALID  in  1 and S_AXI_ARREADY  out  1 SHALL form the read-address handshake.
REQ-012 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1 and S_AXI_RREADY  in  1 SHALL form the read-data channel.
REQ-013 REG0..REG3  out  32 each SHALL expose the current register contents to the neuron datapath.
REQ-014 REG_WR  out  4 SHALL be a one-cycle, one-hot pulse marking which register was written.

Function
REQ-015 Register select SHALL be address bits [3:2]; bits [1:0] are ignored, so 0x0/0x4/0x8/0xC map to REG0..REG3.
REQ-016 AWREADY and WREADY SHALL be registered and rise together for exactly one cycle in the cycle after AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0.
REQ-017 An AW-only or W-only valid SHALL NOT be accepted; the master holds it until its partner arrives.
REQ-018 The register write SHALL occur on the edge where AWREADY=WREADY=1, updating only the byte lanes with WSTRB[n]=1.
REQ-019 REG_WR SHALL pulse in the cycle after the write edge, including for WSTRB=0000.
REQ-020 BVALID SHALL be set on the write edge and SHALL hold, with BRESP=00, until the cycle after BVALID=1 and BREADY=1.
REQ-021 No new write SHALL be accepted while BVALID=1, so at most one write response is outstanding.
REQ-022 ARREADY SHALL be registered and rise for exactly one cycle in the cycle after ARVALID=1, ARREADY=0 and RVALID=0.
REQ-023 On the edge where ARREADY=1, RDATA SHALL capture the selected register and RVALID SHALL be set with RRESP=00.
REQ-024 RDATA/RVALID SHALL hold stable until the cycle after RVALID=1 and RREADY=1; no new read is accepted while RVALID=1.
REQ-025 Read and write paths SHALL be independent; a read and a write to the same register accepted on the same edge SHALL return the pre-write value.
REQ-026 Back-to-back transfers with BREADY/RREADY tied high SHALL sustain one write per 3 cycles and one read per 3 cycles.

Reset
REQ-027 While S_AXI_ARESET=1: AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_WR SHALL be 0; BRESP, RRESP, RDATA SHALL be 0; REG0..REG3 SHALL be 0x00000000.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; no response is issued after reset release.
REQ-029 In the first cycle after reset release, no handshake SHALL be accepted; accepting starts from the next rising edge.

Verification
REQ-030 Writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> RDATA 0x1, 0x2, 0x3, 0x4, all responses OKAY, REG_WR 0001, 0010, 0100, 1000.
REQ-031 Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB=0101 -> REG1=0xFF34FF78.
REQ-032 AWVALID presented 5 cycles before WVALID -> AWREADY stays 0 until WVALID=1, then a single write with one BVALID.
REQ-033 BREADY held 0 for 10 cycles after a write, with a second write pending -> BVALID holds, second write accepted only after the B handshake.
REQ-034 Read and write of REG2 (old 0xA, new 0xB) accepted on the same edge -> RDATA=0xA, subsequent read returns 0xB.
REQ-035 Reset pulsed while RVALID=1 and RREADY=0 -> RVALID=0 and REG0..REG3=0 after one cycle, with no further response.
